// File: rtl/av_switch_seq_pkg.sv
// Shared definitions for the HDMI TX source-switch sequencer and its timer.
package av_switch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MUTE_WAIT = 3'd1,
    ST_SWITCH    = 3'd2,
    ST_LOCK_WAIT = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_UNBLANK   = 3'd5
  } seq_state_t;

  localparam logic SRC_VIDEOGEN = 1'b1;
  localparam logic SRC_SCANCONV = 1'b0;

  localparam int DEF_CLKS_PER_MS = 27000;

endpackage

// File: rtl/av_switch_seq_ms_timer.sv
// Millisecond timeout timer: cycle divider feeding a saturating ms counter.
// Also reused by the LCD backlight timeout logic.
module ms_timer
  import av_switch_seq_pkg::*;
#(
  parameter int CLKS_PER_MS = DEF_CLKS_PER_MS,
  parameter int TIMEOUT_MS  = 100
) (
  input  logic clk27,
  input  logic reset_n,
  input  logic clr,
  output logic to_hit
);

  logic [14:0] cyc_cnt_r;
  logic [9:0]  ms_cnt_r;
  logic        ms_tick_s;

  assign ms_tick_s = (cyc_cnt_r == 15'(CLKS_PER_MS - 1));
  assign to_hit    = (ms_cnt_r == 10'(TIMEOUT_MS));

  // Divide clk27 down to ms ticks; the ms count holds once the limit is reached.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt_r <= 15'd0;
      ms_cnt_r  <= 10'd0;
    end else if (clr) begin
      cyc_cnt_r <= 15'd0;
      ms_cnt_r  <= 10'd0;
    end else if (!to_hit) begin
      if (ms_tick_s) begin
        cyc_cnt_r <= 15'd0;
        ms_cnt_r  <= ms_cnt_r + 10'd1;
      end else begin
        cyc_cnt_r <= cyc_cnt_r + 15'd1;
      end
    end
  end

endmodule

// File: rtl/av_switch_seq.sv
// Glitch-free HDMI TX source switch: blank at a frame edge, flip the mux,
// wait for lock and a few settled frames, then unblank.
module av_switch_seq
  import av_switch_seq_pkg::*;
#(
  parameter int CLKS_PER_MS   = DEF_CLKS_PER_MS,
  parameter int TIMEOUT_MS    = 100,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic       clk27,
  input  logic       reset_n,
  input  logic       sel_req,
  input  logic       vs_out,
  input  logic       src_lock,
  input  logic       clr_flag,
  output logic       sel_out,
  output logic       blank,
  output logic       busy,
  output logic       timeout_flag,
  output logic [7:0] switch_cnt
);

  seq_state_t  state_r;
  logic        target_r;
  logic [3:0]  settle_cnt_r;
  logic        vs_meta_r, vs_sync_r, vs_prev_r;
  logic        lock_meta_r, lock_sync_r;
  logic        sel_out_r, blank_r, busy_r, timeout_flag_r;
  logic [7:0]  switch_cnt_r;
  logic        vs_rise_s, to_hit_s, settle_done_s, adv_s, to_set_s;

  assign sel_out      = sel_out_r;
  assign blank        = blank_r;
  assign busy         = busy_r;
  assign timeout_flag = timeout_flag_r;
  assign switch_cnt   = switch_cnt_r;

  assign vs_rise_s     = vs_sync_r & ~vs_prev_r;
  assign settle_done_s = vs_rise_s && (settle_cnt_r == 4'(SETTLE_FRAMES - 1));

  // Two-flop synchronizers for the async VSYNC and lock inputs, plus edge history.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      vs_meta_r   <= 1'b0;
      vs_sync_r   <= 1'b0;
      vs_prev_r   <= 1'b0;
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      vs_meta_r   <= vs_out;
      vs_sync_r   <= vs_meta_r;
      vs_prev_r   <= vs_sync_r;
      lock_meta_r <= src_lock;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Leave-state and timeout decisions; a real event in the same cycle beats to_hit.
  always_comb begin
    adv_s    = 1'b0;
    to_set_s = 1'b0;
    case (state_r)
      ST_IDLE:      adv_s = (sel_req != sel_out_r);
      ST_MUTE_WAIT: begin
        adv_s    = vs_rise_s | to_hit_s;
        to_set_s = to_hit_s & ~vs_rise_s;
      end
      ST_SWITCH:    adv_s = 1'b1;
      ST_LOCK_WAIT: begin
        adv_s    = lock_sync_r | to_hit_s;
        to_set_s = to_hit_s & ~lock_sync_r;
      end
      ST_SETTLE:    begin
        adv_s    = settle_done_s | to_hit_s;
        to_set_s = to_hit_s & ~settle_done_s;
      end
      ST_UNBLANK:   adv_s = 1'b1;
      default:      adv_s = 1'b1;
    endcase
  end

  // Timer restarts on every state entry.
  ms_timer #(
    .CLKS_PER_MS (CLKS_PER_MS),
    .TIMEOUT_MS  (TIMEOUT_MS)
  ) u_ms_timer (
    .clk27   (clk27),
    .reset_n (reset_n),
    .clr     (adv_s),
    .to_hit  (to_hit_s)
  );

  // Sticky timeout flag; a set in the same cycle as clr_flag wins.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      timeout_flag_r <= 1'b0;
    end else if (to_set_s) begin
      timeout_flag_r <= 1'b1;
    end else if (clr_flag) begin
      timeout_flag_r <= 1'b0;
    end
  end

  // Switch sequencer with registered mux select, blank, busy and switch count.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      target_r     <= SRC_VIDEOGEN;
      settle_cnt_r <= 4'd0;
      sel_out_r    <= SRC_VIDEOGEN;
      blank_r      <= 1'b0;
      busy_r       <= 1'b0;
      switch_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (adv_s) begin
            target_r <= sel_req;
            blank_r  <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= ST_MUTE_WAIT;
          end
        end
        ST_MUTE_WAIT: begin
          if (adv_s) state_r <= ST_SWITCH;
        end
        ST_SWITCH: begin
          sel_out_r <= target_r;
          state_r   <= ST_LOCK_WAIT;
        end
        ST_LOCK_WAIT: begin
          if (adv_s) begin
            settle_cnt_r <= 4'd0;
            state_r      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (adv_s) begin
            state_r <= ST_UNBLANK;
          end else if (vs_rise_s) begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
          end
        end
        ST_UNBLANK: begin
          blank_r      <= 1'b0;
          busy_r       <= 1'b0;
          switch_cnt_r <= switch_cnt_r + 8'd1;
          state_r      <= ST_IDLE;
        end
        default: begin
          blank_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_av_switch_seq.sv
// Directed bench for av_switch_seq with a scaled-down ms timer (100 clocks/ms)
// and a short synthetic VSYNC period of 20 clocks.
module tb_av_switch_seq;

  localparam int CLKS_PER_MS   = 100;
  localparam int TIMEOUT_MS    = 2;
  localparam int SETTLE_FRAMES = 2;

  logic       clk27 = 1'b0;
  logic       reset_n, sel_req, vs_out, src_lock, clr_flag;
  logic       sel_out, blank, busy, timeout_flag;
  logic [7:0] switch_cnt;

  int   checks_cnt = 0;
  int   errors_cnt = 0;
  int   vs_ph;
  logic vs_en;
  int   n, n1, n_to;

  av_switch_seq #(
    .CLKS_PER_MS   (CLKS_PER_MS),
    .TIMEOUT_MS    (TIMEOUT_MS),
    .SETTLE_FRAMES (SETTLE_FRAMES)
  ) dut (
    .clk27        (clk27),
    .reset_n      (reset_n),
    .sel_req      (sel_req),
    .vs_out       (vs_out),
    .src_lock     (src_lock),
    .clr_flag     (clr_flag),
    .sel_out      (sel_out),
    .blank        (blank),
    .busy         (busy),
    .timeout_flag (timeout_flag),
    .switch_cnt   (switch_cnt)
  );

  always #5 clk27 = ~clk27;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs change 1 ns after the edge, VSYNC high for 3 of every 20 clocks.
  task automatic tick();
    @(posedge clk27);
    #1;
    if (vs_en) begin
      vs_ph  = (vs_ph == 19) ? 0 : vs_ph + 1;
      vs_out = (vs_ph < 3);
    end else begin
      vs_out = 1'b0;
    end
  endtask

  task automatic ticks(input int cnt);
    for (int i = 0; i < cnt; i++) tick();
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return sel_out;
      1:       return blank;
      2:       return busy;
      default: return timeout_flag;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input logic val,
                          input int max, output int cnt);
    cnt = 0;
    while (pick(which) !== val && cnt < max) begin
      tick();
      cnt++;
    end
    chk(tag, pick(which), val);
  endtask

  initial begin
    reset_n = 1'b0; sel_req = 1'b1; vs_out = 1'b0; src_lock = 1'b1;
    clr_flag = 1'b0; vs_en = 1'b0; vs_ph = 0; n_to = 0;
    ticks(3);
    chk("rst_sel_out", sel_out, 1);
    chk("rst_blank", blank, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flag", timeout_flag, 0);
    chk("rst_cnt", switch_cnt, 0);
    reset_n = 1'b1;
    ticks(3);

    // Normal switch to the scanconverter.
    sel_req = 1'b0;
    tick();
    chk("t1_blank_next", blank, 1);
    chk("t1_busy_next", busy, 1);
    chk("t1_sel_hold", sel_out, 1);
    vs_ph = 19; vs_en = 1'b1;
    wait_for("t1_flip", 0, 1'b0, 100, n1);
    chk("t1_flip_lat", n1, 5);          // VSYNC rises at tick 1: 2 sync + edge + SWITCH
    wait_for("t1_unblank", 1, 1'b0, 200, n);
    chk("t1_unblank_lat", n1 + n, 45);  // third VSYNC rise at tick 41 + 4
    chk("t1_cnt", switch_cnt, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_sel_final", sel_out, 0);

    // VSYNC stuck low: MUTE_WAIT and SETTLE both time out.
    vs_en = 1'b0;
    ticks(5);
    sel_req = 1'b1;
    n = 0;
    while (sel_out !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (timeout_flag === 1'b1 && n_to == 0) n_to = n;
    end
    chk("t2_flip", sel_out, 1);
    chk("t2_flip_window", ((n - 1) >= 200 && (n - 1) <= 203), 1);
    chk("t2_flag", timeout_flag, 1);
    chk("t2_flag_before_flip", (n_to > 0 && n_to < n), 1);
    wait_for("t2_done", 2, 1'b0, 800, n);
    chk("t2_blank", blank, 0);
    chk("t2_cnt", switch_cnt, 2);
    clr_flag = 1'b1; tick(); clr_flag = 1'b0; tick();
    chk("t2_clr", timeout_flag, 0);

    // Lock never arrives: timeout in LOCK_WAIT, SETTLE still waits for frames.
    src_lock = 1'b0;
    ticks(4);
    sel_req = 1'b0;
    vs_ph = 19; vs_en = 1'b1;
    wait_for("t3_flip", 0, 1'b0, 100, n);
    chk("t3_no_flag_yet", timeout_flag, 0);
    wait_for("t3_flag", 3, 1'b1, 400, n);
    chk("t3_blank_held", blank, 1);
    chk("t3_busy_held", busy, 1);
    wait_for("t3_done", 2, 1'b0, 200, n);
    chk("t3_blank", blank, 0);
    chk("t3_cnt", switch_cnt, 3);
    src_lock = 1'b1;
    clr_flag = 1'b1; tick(); clr_flag = 1'b0; tick();
    chk("t3_clr", timeout_flag, 0);

    // Back to the pattern generator, then a 1->0->1 toggle during SETTLE.
    sel_req = 1'b1;
    tick();
    wait_for("t4_setup", 2, 1'b0, 200, n);
    chk("t4_setup_cnt", switch_cnt, 4);
    sel_req = 1'b0;
    wait_for("t4_flip", 0, 1'b0, 100, n);
    ticks(3);
    sel_req = 1'b1; ticks(2);
    sel_req = 1'b0; ticks(2);
    sel_req = 1'b1;
    wait_for("t4_first_done", 2, 1'b0, 200, n);
    chk("t4_first_sel", sel_out, 0);
    chk("t4_first_blank", blank, 0);
    chk("t4_first_cnt", switch_cnt, 5);
    tick();
    chk("t4_restart", busy, 1);
    wait_for("t4_second_done", 2, 1'b0, 200, n);
    chk("t4_final_sel", sel_out, 1);
    chk("t4_final_cnt", switch_cnt, 6);

    // Asynchronous reset in the middle of SETTLE.
    sel_req = 1'b0;
    wait_for("t5_flip", 0, 1'b0, 100, n);
    ticks(3);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_sel", sel_out, 1);
    chk("t5_blank", blank, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cnt", switch_cnt, 0);
    sel_req = 1'b1;
    ticks(2);
    reset_n = 1'b1;
    ticks(2);

    // 256 completed switches wrap the count to 0.
    for (int i = 0; i < 256; i++) begin
      sel_req = ~sel_req;
      tick();
      wait_for("t6_sw_done", 2, 1'b0, 200, n);
      if (i == 254) chk("t6_cnt_255", switch_cnt, 255);
    end
    chk("t6_wrap", switch_cnt, 0);

    // clr_flag on the very edge where the MUTE_WAIT timeout sets the flag.
    chk("t7_flag_clear", timeout_flag, 0);
    vs_en = 1'b0;
    ticks(5);
    sel_req = ~sel_req;
    ticks(n_to - 1);
    clr_flag = 1'b1;
    tick();
    clr_flag = 1'b0;
    ticks(2);
    chk("t7_set_wins", timeout_flag, 1);
    wait_for("t7_done", 2, 1'b0, 800, n);
    chk("t7_cnt", switch_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/av_switch_seq.md
# av_switch_seq

Sequencer for glitch-free switching of the HDMI TX output between the scanconverter path and the internal test-pattern generator. It sits between the CPU control register bit and the output source mux. On a select change it blanks the output at a frame boundary and flips the mux. It then waits for the new source to lock and settle before unblanking. It also counts completed switches and flags timeouts for firmware.

## Interface
Parameters:
- CLKS_PER_MS, 27000, clk27 cycles per millisecond.
- TIMEOUT_MS, 100, max wait for VSYNC edge or lock, in ms (≤ 1023).
- SETTLE_FRAMES, 2, VSYNC rising edges on the new source before unblank (1..15).

Ports:
- clk27  in  1  system clock, 27 MHz.
- reset_n  in  1  asynchronous active-low reset.
- sel_req  in  1  requested source: 1 = test-pattern generator, 0 = scanconverter. Level, clk27 domain.
- vs_out  in  1  VSYNC currently driven to the TX, asynchronous; synchronized internally.
- src_lock  in  1  target-source lock. Tie 1 for the pattern generator; PLL-lock indication for the scanconverter. Asynchronous; synchronized internally.
- sel_out  out  1  mux select to the output path.
- blank  out  1  forces DE and RGB to 0 at the output mux.
- busy  out  1  sequence in progress.
- timeout_flag  out  1  sticky; set on any timeout; cleared by clr_flag.
- clr_flag  in  1  single-cycle pulse that clears timeout_flag.
- switch_cnt  out  8  completed switches, wraps at 255→0.

## Operation
- vs_out and src_lock pass through 2-flop synchronizers. A VSYNC rising edge is detected on the 3rd clk27 after the async edge, as a 1-cycle vs_rise.
- Timeout timer: 15-bit cycle counter plus 10-bit ms counter. Cleared on every state entry. to_hit asserts when ms count == TIMEOUT_MS.
- FSM states and transitions:
  - IDLE: when sel_req != sel_out, latch target ← sel_req and go to MUTE_WAIT.
  - MUTE_WAIT: blank=1. On vs_rise or to_hit, go to SWITCH. to_hit also sets timeout_flag.
  - SWITCH: one cycle. sel_out ← target. Go to LOCK_WAIT.
  - LOCK_WAIT: when the synchronized src_lock is 1, go to SETTLE. On to_hit, set timeout_flag and go to SETTLE.
  - SETTLE: count vs_rise. On count == SETTLE_FRAMES or to_hit, go to UNBLANK. to_hit also sets timeout_flag.
  - UNBLANK: one cycle. blank ← 0, switch_cnt += 1. Go to IDLE.
- busy = (state != IDLE).
- target is latched only in IDLE. sel_req changes during a sequence are ignored until IDLE. If sel_req still differs from sel_out on return to IDLE, a new sequence starts the next cycle.
- A sel_req toggle and return to the original value during a sequence completes the sequence. The mismatch then restarts a sequence back.
- If clr_flag and a timeout-set occur in the same cycle, set wins.
- If vs_rise and to_hit occur in the same cycle in MUTE_WAIT or SETTLE, the state advances and timeout_flag is not set.
- When reset asserts mid-sequence, all state returns to reset values immediately. Reset is asynchronous.

## Timing
- Reset values:
  - sel_out=1 (pattern generator, matching the sys_ctrl reset).
  - blank=0, busy=0, timeout_flag=0, switch_cnt=0.
  - state=IDLE, all counters 0.
- All outputs are registered.
- sel_req mismatch → busy and blank high on the next edge (1-cycle latency).
- blank rises before sel_out changes. sel_out changes exactly 1 cycle after MUTE_WAIT exits.
- blank falls and switch_cnt increments on the same edge, 1 cycle after SETTLE exits.
- Minimum sequence with src_lock=1 and SETTLE_FRAMES=1 is bounded by the two VSYNC waits plus synchronizer latency.
- Worst case is 3 × TIMEOUT_MS + 3 cycles.

## Structure
- Shared package holds:
  - the FSM state encoding (6 states, 3 bits);
  - SRC_VIDEOGEN=1'b1 and SRC_SCANCONV=1'b0;
  - the default CLKS_PER_MS constant.
- Natural sub-module: ms_timer. It holds the cycle-divider and ms counter, with clear input and to_hit output, and is reusable by the LCD backlight timeout logic.
- The synchronizers are inline.

## Test plan
- Reset, then sel_req=0, vs_out at 60 Hz, src_lock=1, SETTLE_FRAMES=2 → blank=1 next cycle; sel_out=0 one cycle after the first synced VSYNC edge; blank=0 after 2 further edges; switch_cnt=1; busy=0.
- vs_out stuck low, TIMEOUT_MS=2 → sel_out flips 54000 cycles after MUTE_WAIT entry; timeout_flag=1. clr_flag pulse → flag 0.
- src_lock held 0 in LOCK_WAIT → timeout_flag set after TIMEOUT_MS; SETTLE still runs; blank drops after SETTLE_FRAMES edges.
- sel_req 1→0→1 toggled during SETTLE → first sequence completes (sel_out=0), then a second sequence runs; final sel_out=1, switch_cnt=2.
- Reset asserted in SETTLE → sel_out=1, blank=0, busy=0 asynchronously; switch_cnt=0.
- 256 completed switches → switch_cnt wraps to 0. A clr_flag pulse coinciding with a timeout cycle leaves timeout_flag=1.
